// File: rtl/lcd1602_pkg.sv
// Shared HD44780 bus constants, responder FSM states and the address-counter step rule.
package lcd1602_pkg;

    localparam int ACW = 7;

    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_ENTRY   = 8'h04;
    localparam logic [7:0] CMD_DISPLAY = 8'h08;
    localparam logic [7:0] CMD_SHIFT   = 8'h10;
    localparam logic [7:0] CMD_FUNC    = 8'h20;
    localparam logic [7:0] CMD_CGRAM   = 8'h40;
    localparam logic [7:0] CMD_DDRAM   = 8'h80;

    localparam logic [ACW-1:0] LINE0_BASE = 7'h00;
    localparam logic [ACW-1:0] LINE1_BASE = 7'h40;
    localparam logic [ACW-1:0] LINE0_LAST = 7'h27;
    localparam logic [ACW-1:0] LINE1_LAST = 7'h67;

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_CLEAR = 2'd1,
        S_IDLE  = 2'd2,
        S_EXEC  = 2'd3
    } state_t;

    // Line ends wrap to the other line's base; anything else is a plain 7-bit +/-1.
    function automatic logic [ACW-1:0] ac_step(input logic [ACW-1:0] a, input logic inc);
        logic [ACW-1:0] r;
        if (inc) begin
            if (a == LINE0_LAST)      r = LINE1_BASE;
            else if (a == LINE1_LAST) r = LINE0_BASE;
            else                      r = a + 7'd1;
        end else begin
            if (a == LINE0_BASE)      r = LINE1_LAST;
            else if (a == LINE1_BASE) r = LINE0_LAST;
            else                      r = a - 7'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd1602_ddram.sv
// DDRAM shadow: one write port, registered host read port (read-before-write on same address).
// LCD_READ_EN adds a second registered read port for bus reads.
module lcd1602_ddram #(
    parameter int DEPTH     = 32,
    parameter int DATA_BITS = 8,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [AW-1:0]        rd_addr,
`ifdef LCD_READ_EN
    input  logic [AW-1:0]        rd2_addr,
    output logic [DATA_BITS-1:0] rd2_data,
`endif
    output logic [DATA_BITS-1:0] rd_data
);

    logic [DATA_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data <= '0;
        else        rd_data <= mem[rd_addr];
    end

`ifdef LCD_READ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd2_data <= '0;
        else        rd2_data <= mem[rd2_addr];
    end
`endif

endmodule

// File: rtl/lcd1602_bus_responder.sv
// HD44780 8-bit bus responder: synchronizes the bus, executes each strobe two cycles after the
// synced enable falls, mirrors DDRAM for host readback. LCD_READ_EN adds bus read-back drive.
module lcd1602_bus_responder
    import lcd1602_pkg::*;
#(
    parameter int         NUM_COLS    = 16,
    parameter int         NUM_ROWS    = 2,
    parameter int         DATA_BITS   = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CLEAR_FILL  = 8'h20,
    parameter int         DEPTH       = NUM_COLS * NUM_ROWS,
    parameter int         IDX_W       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 lcd_rs,
    input  logic                 lcd_rw,
    input  logic                 lcd_en,
    input  logic [DATA_BITS-1:0] lcd_data,
    input  logic [IDX_W-1:0]     rd_addr,
    output logic [DATA_BITS-1:0] rd_data,
    output logic [6:0]           ac,
    output logic                 display_on,
    output logic                 cursor_on,
    output logic                 blink_on,
    output logic                 entry_inc,
    output logic                 entry_shift,
    output logic                 cfg_8bit,
    output logic                 cfg_2line,
    output logic                 busy,
    output logic                 cmd_valid,
    output logic [DATA_BITS-1:0] cmd_code,
    output logic                 char_valid,
    output logic [IDX_W-1:0]     char_idx,
    output logic                 err_busy,
`ifdef LCD_READ_EN
    output logic [DATA_BITS-1:0] lcd_data_o,
    output logic                 lcd_data_oe,
`endif
    output logic                 err_offscreen
);

`ifdef LCD_READ_EN
    localparam logic READ_EN = 1'b1;
`else
    localparam logic READ_EN = 1'b0;
`endif

    logic [SYNC_STAGES-1:0] en_sync, rs_sync, rw_sync;
    logic [DATA_BITS-1:0]   data_sync [SYNC_STAGES];
    logic                   en_s, rs_s, rw_s, en_d;
    logic [DATA_BITS-1:0]   data_s;
    logic                   strobe;

    logic                 cap_rs, cap_rw;
    logic [DATA_BITS-1:0] cap_data;
    logic                 is_clear;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] clr_idx;
    logic             accept, drop, clr_we, exec_cmd, exec_wr;

    logic                 vis;
    logic [IDX_W-1:0]     row_base, ac_idx;
    logic                 ram_we;
    logic [IDX_W-1:0]     ram_waddr;
    logic [DATA_BITS-1:0] ram_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_sync <= '0;
            rs_sync <= '0;
            rw_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
            en_d    <= 1'b0;
        end else begin
            en_sync      <= {en_sync[SYNC_STAGES-2:0], lcd_en};
            rs_sync      <= {rs_sync[SYNC_STAGES-2:0], lcd_rs};
            rw_sync      <= {rw_sync[SYNC_STAGES-2:0], lcd_rw};
            data_sync[0] <= lcd_data;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
            en_d         <= en_s;
        end
    end

    assign en_s   = en_sync[SYNC_STAGES-1];
    assign rs_s   = rs_sync[SYNC_STAGES-1];
    assign rw_s   = rw_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    // Read strobes are invisible unless bus read-back is built in.
    assign strobe = en_d & ~en_s & (~rw_s | READ_EN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_rs   <= 1'b0;
            cap_rw   <= 1'b0;
            cap_data <= '0;
        end else if (accept) begin
            cap_rs   <= rs_s;
            cap_rw   <= rw_s;
            cap_data <= data_s;
        end
    end

    assign is_clear = ~cap_rs & ~cap_rw & (cap_data == CMD_CLEAR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_RST;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:   state_nxt = S_CLEAR;
            S_CLEAR: if (clr_idx == IDX_W'(DEPTH - 1)) state_nxt = S_IDLE;
            S_IDLE:  if (strobe) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = is_clear ? S_CLEAR : S_IDLE;
            default: state_nxt = S_RST;
        endcase
    end

    always_comb begin
        busy     = (state == S_CLEAR);
        clr_we   = (state == S_CLEAR);
        accept   = (state == S_IDLE) & strobe;
        drop     = (state != S_IDLE) & strobe;
        exec_cmd = (state == S_EXEC) & ~cap_rs & ~cap_rw;
        exec_wr  = (state == S_EXEC) &  cap_rs & ~cap_rw;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      clr_idx <= '0;
        else if (clr_we) clr_idx <= clr_idx + 1'b1;
        else             clr_idx <= '0;
    end

    assign vis      = ac[5:0] < 6'(NUM_COLS);
    assign row_base = ac[6] ? IDX_W'(NUM_COLS) : '0;
    assign ac_idx   = row_base + IDX_W'(ac[5:0]);

    assign ram_we    = clr_we | (exec_wr & vis);
    assign ram_waddr = clr_we ? clr_idx : ac_idx;
    assign ram_wdata = clr_we ? CLEAR_FILL : cap_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ac            <= '0;
            display_on    <= 1'b0;
            cursor_on     <= 1'b0;
            blink_on      <= 1'b0;
            entry_inc     <= 1'b1;
            entry_shift   <= 1'b0;
            cfg_8bit      <= 1'b1;
            cfg_2line     <= 1'b0;
            cmd_valid     <= 1'b0;
            cmd_code      <= '0;
            char_valid    <= 1'b0;
            char_idx      <= '0;
            err_busy      <= 1'b0;
            err_offscreen <= 1'b0;
        end else begin
            cmd_valid  <= exec_cmd;
            char_valid <= exec_wr & vis;
            if (drop) err_busy <= 1'b1;
            if (exec_cmd) begin
                cmd_code <= cap_data;
                priority casez (cap_data)
                    8'b1???????: ac <= cap_data[6:0];
                    8'b01??????: ;
                    8'b001?????: begin
                        cfg_8bit  <= cap_data[4];
                        cfg_2line <= cap_data[3];
                    end
                    8'b0001????: if (!cap_data[3]) ac <= ac_step(ac, cap_data[2]);
                    8'b00001???: begin
                        display_on <= cap_data[2];
                        cursor_on  <= cap_data[1];
                        blink_on   <= cap_data[0];
                    end
                    8'b000001??: begin
                        entry_inc   <= cap_data[1];
                        entry_shift <= cap_data[0];
                    end
                    8'b0000001?: ac <= '0;
                    8'b00000001: begin
                        ac        <= '0;
                        entry_inc <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (exec_wr) begin
                if (vis) char_idx      <= ac_idx;
                else     err_offscreen <= 1'b1;
                ac <= ac_step(ac, entry_inc);
            end
`ifdef LCD_READ_EN
            if ((state == S_EXEC) && cap_rs && cap_rw) ac <= ac_step(ac, entry_inc);
`endif
        end
    end

`ifdef LCD_READ_EN
    logic [DATA_BITS-1:0] rd2_data;

    assign lcd_data_oe = rw_s & en_s;
    assign lcd_data_o  = rs_s ? (vis ? rd2_data : '0) : {busy, ac};
`endif

    lcd1602_ddram #(
        .DEPTH     (DEPTH),
        .DATA_BITS (DATA_BITS)
    ) u_ddram (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (ram_we),
        .wr_addr  (ram_waddr),
        .wr_data  (ram_wdata),
        .rd_addr  (rd_addr),
`ifdef LCD_READ_EN
        .rd2_addr (ac_idx),
        .rd2_data (rd2_data),
`endif
        .rd_data  (rd_data)
    );

endmodule

// File: tb/tb_lcd1602_bus_responder.sv
// Directed bench: vector table of bus writes with hand-computed AC/flag/pulse results, then sweeps.
module tb_lcd1602_bus_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [6:0] ac;
    logic       display_on, cursor_on, blink_on, entry_inc, entry_shift, cfg_8bit, cfg_2line;
    logic       busy, cmd_valid, char_valid, err_busy, err_offscreen;
    logic [7:0] cmd_code;
    logic [4:0] char_idx;
`ifdef LCD_READ_EN
    logic [7:0] lcd_data_o;
    logic       lcd_data_oe;
`endif

    always #5 clk = ~clk;

    lcd1602_bus_responder dut (
        .clk(clk), .reset(reset), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_data(rd_data), .ac(ac),
        .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .entry_inc(entry_inc), .entry_shift(entry_shift), .cfg_8bit(cfg_8bit),
        .cfg_2line(cfg_2line), .busy(busy), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .char_valid(char_valid), .char_idx(char_idx), .err_busy(err_busy),
`ifdef LCD_READ_EN
        .lcd_data_o(lcd_data_o), .lcd_data_oe(lcd_data_oe),
`endif
        .err_offscreen(err_offscreen)
    );

    int         errors = 0;
    int         checks = 0;
    int         cmd_cnt = 0;
    int         chr_cnt = 0;
    logic [7:0] last_code = '0;
    logic [4:0] last_idx = '0;

    always @(negedge clk) begin
        if (cmd_valid) begin
            cmd_cnt   <= cmd_cnt + 1;
            last_code <= cmd_code;
        end
        if (char_valid) begin
            chr_cnt  <= chr_cnt + 1;
            last_idx <= char_idx;
        end
    end

    // {display_on, cursor_on, blink_on, entry_inc, entry_shift, cfg_8bit, cfg_2line, err_busy, err_offscreen}
    logic [8:0] flags;
    assign flags = {display_on, cursor_on, blink_on, entry_inc, entry_shift,
                    cfg_8bit, cfg_2line, err_busy, err_offscreen};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_strobe(input logic rs_i, input logic rw_i, input logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs_i; lcd_rw = rw_i; lcd_data = d; lcd_en = 1'b1;
        repeat (4) @(negedge clk);
        lcd_en = 1'b0;
    endtask

    task automatic bus_write(input logic rs_i, input logic rw_i, input logic [7:0] d);
        bus_strobe(rs_i, rw_i, d);
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", busy, 0);
    endtask

    task automatic measure_busy(output int cnt);
        int n = 0;
        cnt = 0;
        while (!busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        while (busy && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic read_ram(input logic [4:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
    endtask

    typedef struct {
        logic       rs;
        logic       rw;
        logic [7:0] d;
        logic [6:0] ac;
        int         ncmd;
        int         nchr;
        logic [4:0] idx;
        logic [8:0] flags;
    } vec_t;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
    } rv_t;

    vec_t vecs [31];
    rv_t  rvs  [9];

    initial begin
        int         c0, h0, bcnt;
        logic [7:0] rv, v2, v3;

        vecs[0]  = '{0, 0, 8'h38, 7'h00, 1, 0, 5'd0,  9'b000101100};
        vecs[1]  = '{0, 0, 8'h06, 7'h00, 1, 0, 5'd0,  9'b000101100};
        vecs[2]  = '{0, 0, 8'h0C, 7'h00, 1, 0, 5'd0,  9'b100101100};
        vecs[3]  = '{0, 0, 8'h01, 7'h00, 1, 0, 5'd0,  9'b100101100};
        vecs[4]  = '{1, 0, 8'h48, 7'h01, 0, 1, 5'd0,  9'b100101100};
        vecs[5]  = '{1, 0, 8'h4F, 7'h02, 0, 1, 5'd1,  9'b100101100};
        vecs[6]  = '{1, 0, 8'h4C, 7'h03, 0, 1, 5'd2,  9'b100101100};
        vecs[7]  = '{1, 0, 8'h41, 7'h04, 0, 1, 5'd3,  9'b100101100};
        vecs[8]  = '{1, 1, 8'hFF, 7'h04, 0, 0, 5'd0,  9'b100101100};
        vecs[9]  = '{0, 0, 8'hC0, 7'h40, 1, 0, 5'd0,  9'b100101100};
        vecs[10] = '{1, 0, 8'h5A, 7'h41, 0, 1, 5'd16, 9'b100101100};
        vecs[11] = '{0, 0, 8'h8F, 7'h0F, 1, 0, 5'd0,  9'b100101100};
        vecs[12] = '{1, 0, 8'h41, 7'h10, 0, 1, 5'd15, 9'b100101100};
        vecs[13] = '{1, 0, 8'h42, 7'h11, 0, 0, 5'd0,  9'b100101101};
        vecs[14] = '{0, 0, 8'h04, 7'h11, 1, 0, 5'd0,  9'b100001101};
        vecs[15] = '{0, 0, 8'h80, 7'h00, 1, 0, 5'd0,  9'b100001101};
        vecs[16] = '{1, 0, 8'h31, 7'h67, 0, 1, 5'd0,  9'b100001101};
        vecs[17] = '{0, 0, 8'hA7, 7'h27, 1, 0, 5'd0,  9'b100001101};
        vecs[18] = '{0, 0, 8'h06, 7'h27, 1, 0, 5'd0,  9'b100101101};
        vecs[19] = '{1, 0, 8'h39, 7'h40, 0, 0, 5'd0,  9'b100101101};
        vecs[20] = '{0, 0, 8'hE7, 7'h67, 1, 0, 5'd0,  9'b100101101};
        vecs[21] = '{1, 0, 8'h3B, 7'h00, 0, 0, 5'd0,  9'b100101101};
        vecs[22] = '{0, 0, 8'h10, 7'h67, 1, 0, 5'd0,  9'b100101101};
        vecs[23] = '{0, 0, 8'h14, 7'h00, 1, 0, 5'd0,  9'b100101101};
        vecs[24] = '{0, 0, 8'h18, 7'h00, 1, 0, 5'd0,  9'b100101101};
        vecs[25] = '{0, 0, 8'h40, 7'h00, 1, 0, 5'd0,  9'b100101101};
        vecs[26] = '{0, 0, 8'h00, 7'h00, 1, 0, 5'd0,  9'b100101101};
        vecs[27] = '{0, 0, 8'h85, 7'h05, 1, 0, 5'd0,  9'b100101101};
        vecs[28] = '{0, 0, 8'h02, 7'h00, 1, 0, 5'd0,  9'b100101101};
        vecs[29] = '{0, 0, 8'h0F, 7'h00, 1, 0, 5'd0,  9'b111101101};
        vecs[30] = '{0, 0, 8'h20, 7'h00, 1, 0, 5'd0,  9'b111100001};

        rvs[0] = '{5'd0,  8'h31};
        rvs[1] = '{5'd1,  8'h4F};
        rvs[2] = '{5'd2,  8'h4C};
        rvs[3] = '{5'd3,  8'h41};
        rvs[4] = '{5'd4,  8'h20};
        rvs[5] = '{5'd15, 8'h41};
        rvs[6] = '{5'd16, 8'h5A};
        rvs[7] = '{5'd17, 8'h20};
        rvs[8] = '{5'd31, 8'h20};

        reset = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_en = 1'b0; lcd_data = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ac", ac, 0);
        check("rst_flags", flags, 9'b000101000);
        check("rst_pulses", {cmd_valid, char_valid}, 0);
        check("rst_rd_data", rd_data, 0);

        reset = 1'b1;
        measure_busy(bcnt);
        check("init_sweep_len", bcnt, 32);
        for (int i = 0; i < 32; i++) begin
            read_ram(5'(i), rv);
            check($sformatf("init_fill[%0d]", i), rv, 8'h20);
        end

        for (int i = 0; i < 31; i++) begin
            c0 = cmd_cnt;
            h0 = chr_cnt;
            bus_write(vecs[i].rs, vecs[i].rw, vecs[i].d);
            if (!vecs[i].rs && vecs[i].d == 8'h01) check($sformatf("v%0d_busy", i), busy, 1);
            wait_idle();
            check($sformatf("v%0d_ac", i), ac, vecs[i].ac);
            check($sformatf("v%0d_ncmd", i), cmd_cnt - c0, vecs[i].ncmd);
            check($sformatf("v%0d_nchr", i), chr_cnt - h0, vecs[i].nchr);
            check($sformatf("v%0d_flags", i), flags, vecs[i].flags);
            if (vecs[i].ncmd == 1) check($sformatf("v%0d_code", i), last_code, vecs[i].d);
            if (vecs[i].nchr == 1) check($sformatf("v%0d_idx", i), last_idx, vecs[i].idx);
        end

        for (int i = 0; i < 9; i++) begin
            read_ram(rvs[i].a, rv);
            check($sformatf("ram[%0d]", rvs[i].a), rv, rvs[i].d);
        end

        // Clear sweep over index 1 while reading it: old byte one cycle after its write.
        @(negedge clk);
        rd_addr = 5'd1;
        bus_strobe(0, 0, 8'h01);
        bcnt = 0;
        while (!busy && bcnt < 30) begin
            @(negedge clk);
            bcnt++;
        end
        check("clr_started", busy, 1);
        @(negedge clk);
        @(negedge clk);
        v2 = rd_data;
        @(negedge clk);
        v3 = rd_data;
        check("rbw_old", v2, 8'h4F);
        check("rbw_new", v3, 8'h20);

        h0 = chr_cnt;
        bus_write(1, 0, 8'h55);
        check("drop_nchr", chr_cnt - h0, 0);
        check("err_busy", err_busy, 1);
        wait_idle();
        check("drop_ac", ac, 0);
        read_ram(5'd0, rv);
        check("drop_ram0", rv, 8'h20);

        bus_strobe(0, 0, 8'h01);
        repeat (10) @(negedge clk);
        check("mid_sweep_busy", busy, 1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst2_busy", busy, 0);
        check("rst2_ac", ac, 0);
        check("rst2_flags", flags, 9'b000101000);
        check("rst2_rd_data", rd_data, 0);
        reset = 1'b1;
        measure_busy(bcnt);
        check("rst2_sweep_len", bcnt, 32);
        read_ram(5'd2, rv);
        check("rst2_ram2", rv, 8'h20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
